t1us_gen: RTL and testbench
===========================

T1US_GEN -- requirements
Module: t1us_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 3, number of synchronizer flops on sync_in (min 2).
REQ-002 Parameter US_PER_SEC, default 1000000, number of t1us periods per second marker.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 en  input  1  generator enable; 0 holds output idle.
REQ-006 div  input  16  clk cycles per t1us period.
REQ-007 hi_len  input  16  clk cycles t1us is high per period.
REQ-008 sync_in  input  1  asynchronous external alignment strobe; its rising edge is the event.
REQ-009 t1us  output  1  registered microsecond pulse train for downstream counters.
REQ-010 usec_cnt  output  32  count of t1us rising edges since reset or last alignment.
REQ-011 sec_pulse  output  1  one-clk strobe at the start of each second.
REQ-012 locked  output  1  set by first alignment, cleared only by reset.
REQ-013 sync_err  output  1  sticky: alignment arrived off a period boundary while locked.

Function
REQ-014 FSM states IDLE, HIGH, LOW; 16-bit phase counter ph counts clocks within the current state.
REQ-015 IDLE: t1us=0, ph=0; en=1 moves the FSM to HIGH on the next clock.
REQ-016 Entering HIGH is a period start: latch div and hi_len into shadow registers, t1us=1 in the same cycle, increment usec_cnt.
REQ-017 Clamping on latch: div<2 -> 2; hi_len=0 -> 1; hi_len>=div -> div-1.
REQ-018 HIGH lasts hi_len clocks, then LOW lasts div-hi_len clocks, then HIGH (new period); period = div clocks exactly.
REQ-019 div/hi_len changes mid-period take effect only at the next period start.
REQ-020 en=0 in any state -> IDLE next clock, t1us=0; usec_cnt holds its value.
REQ-021 sync_in passes through SYNC_STAGES flops plus a rising-edge detector; the detected edge is sync_ev (one clk).
REQ-022 sync_ev with en=1: the next clock is a forced period start, usec_cnt loads 1 (not incremented), second counter loads 0, sec_pulse=1, locked=1.
REQ-023 Latency sync_in rising -> t1us rising = SYNC_STAGES+2 clocks from the first sampling clk edge.
REQ-024 sync_ev on the last LOW cycle of a period (natural boundary): forced start coincides with natural start; no extra pulse, sync_err unchanged.
REQ-025 sync_ev anywhere else while locked=1: sync_err=1 (sticky); restart still occurs.
REQ-026 sync_ev with en=0: ignored entirely; en=0 has priority.
REQ-027 Second counter (20 bits sized for US_PER_SEC) increments per period start; sec_pulse=1 at the period start where it wraps from US_PER_SEC-1 to 0.
REQ-028 usec_cnt wraps 0xFFFFFFFF -> 0 silently.
REQ-029 All outputs registered; no combinational path input -> output.

Reset
REQ-030 Reset mid-operation: next clock state IDLE, t1us=0, usec_cnt=0, second counter=0, sec_pulse=0, locked=0, sync_err=0, synchronizer flops=0.
REQ-031 reset has priority over en and sync_ev.

Structure
REQ-032 Package t1us_pkg holds the FSM state enum, SYNC_STAGES and US_PER_SEC defaults, and clamp minimum constants.
REQ-033 One sub-module edge_sync (parameterized synchronizer + rising-edge detect) instantiated for sync_in.

Verification
REQ-034 div=100, hi_len=50, en=1 -> t1us 50 high/50 low, usec_cnt +1 every 100 clocks, first rise 1 clk after en.
REQ-035 div=1, hi_len=0 -> period 2 clocks, high 1 clock; div=10, hi_len=12 -> high 9, low 1.
REQ-036 Locked, div=100, sync_in rises at ph=30 of LOW -> t1us restarts after SYNC_STAGES+2 clocks, usec_cnt=1, sec_pulse=1, sync_err=1.
REQ-037 US_PER_SEC=10 override, div=4 -> sec_pulse every 40 clocks, coincident with t1us rise.
REQ-038 Change div 100->20 at ph=10 of HIGH -> current period 100 clocks, next 20.
REQ-039 reset asserted during HIGH with usec_cnt=5 -> next clock t1us=0, usec_cnt=0, locked=0, sync_err=0.

Source files
------------

// File: rtl/t1us_pkg.sv
// Shared types and constants for the microsecond pulse generator:
// FSM states, parameter defaults and the div/hi_len clamping helper.
package t1us_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int SYNC_STAGES_DEFAULT = 3;
    localparam int US_PER_SEC_DEFAULT  = 1000000;

    localparam logic [15:0] DIV_MIN = 16'd2;
    localparam logic [15:0] HI_MIN  = 16'd1;

    typedef struct packed {
        logic [15:0] div;
        logic [15:0] hi;
    } period_t;

    // Guarantees at least one high and one low cycle in every period.
    function automatic period_t clamp_period(input logic [15:0] div_in, input logic [15:0] hi_in);
        period_t p;
        p.div = (div_in < DIV_MIN) ? DIV_MIN : div_in;
        p.hi  = (hi_in < HI_MIN) ? HI_MIN : hi_in;
        if (p.hi >= p.div) begin
            p.hi = p.div - 16'd1;
        end
        return p;
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous strobe followed by a
// registered rising-edge detector producing a one-clock event.
module edge_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic ev
);

    logic [STAGES-1:0] sync_reg;
    logic              prev_reg;
    logic              ev_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
            ev_reg   <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], din};
            prev_reg <= sync_reg[STAGES-1];
            ev_reg   <= sync_reg[STAGES-1] & ~prev_reg;
        end
    end

    assign ev = ev_reg;

endmodule

// File: rtl/t1us_gen.sv
// Programmable microsecond pulse generator with per-second marker and
// alignment to an external asynchronous strobe.
module t1us_gen
    import t1us_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int US_PER_SEC  = US_PER_SEC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] div,
    input  logic [15:0] hi_len,
    input  logic        sync_in,
    output logic        t1us,
    output logic [31:0] usec_cnt,
    output logic        sec_pulse,
    output logic        locked,
    output logic        sync_err
);

    localparam int SEC_W = (US_PER_SEC > 1) ? $clog2(US_PER_SEC) : 1;
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(US_PER_SEC - 1);

    state_t            state_reg, state_next;
    logic [15:0]       ph_reg, ph_next;
    period_t           shadow_reg, shadow_next;
    logic              t1us_reg, t1us_next;
    logic [31:0]       usec_reg, usec_next;
    logic [SEC_W-1:0]  sec_reg, sec_next;
    logic              sec_pulse_reg, sec_pulse_next;
    logic              locked_reg, locked_next;
    logic              err_reg, err_next;

    logic              sync_ev;
    logic [15:0]       lo_len;
    logic              natural_start;
    logic              forced;
    logic              start;

    edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .din  (sync_in),
        .ev   (sync_ev)
    );

    // A natural start is the clock after IDLE (when enabled) or after the last LOW cycle.
    assign lo_len        = shadow_reg.div - shadow_reg.hi;
    assign natural_start = (state_reg == IDLE) ||
                           ((state_reg == LOW) && (ph_reg == lo_len - 16'd1));
    assign forced        = en & sync_ev;
    assign start         = en & (natural_start | sync_ev);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            ph_reg        <= 16'd0;
            shadow_reg    <= '{div: DIV_MIN, hi: HI_MIN};
            t1us_reg      <= 1'b0;
            usec_reg      <= 32'd0;
            sec_reg       <= '0;
            sec_pulse_reg <= 1'b0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ph_reg        <= ph_next;
            shadow_reg    <= shadow_next;
            t1us_reg      <= t1us_next;
            usec_reg      <= usec_next;
            sec_reg       <= sec_next;
            sec_pulse_reg <= sec_pulse_next;
            locked_reg    <= locked_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ph_next    = ph_reg + 16'd1;
        if (!en) begin
            state_next = IDLE;
            ph_next    = 16'd0;
        end else if (start) begin
            state_next = HIGH;
            ph_next    = 16'd0;
        end else begin
            case (state_reg)
                HIGH: begin
                    if (ph_reg == shadow_reg.hi - 16'd1) begin
                        state_next = LOW;
                        ph_next    = 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        t1us_next      = (state_next == HIGH);
        shadow_next    = shadow_reg;
        usec_next      = usec_reg;
        sec_next       = sec_reg;
        sec_pulse_next = 1'b0;
        locked_next    = locked_reg;
        err_next       = err_reg;
        if (start) begin
            shadow_next = clamp_period(div, hi_len);
        end
        if (forced) begin
            usec_next      = 32'd1;
            sec_next       = '0;
            sec_pulse_next = 1'b1;
            locked_next    = 1'b1;
            // Alignment that lands exactly on a boundary is in phase and not an error.
            if (locked_reg && !natural_start) begin
                err_next = 1'b1;
            end
        end else if (start) begin
            usec_next = usec_reg + 32'd1;
            if (sec_reg == SEC_LAST) begin
                sec_next       = '0;
                sec_pulse_next = 1'b1;
            end else begin
                sec_next = sec_reg + SEC_W'(1);
            end
        end
    end

    assign t1us      = t1us_reg;
    assign usec_cnt  = usec_reg;
    assign sec_pulse = sec_pulse_reg;
    assign locked    = locked_reg;
    assign sync_err  = err_reg;

endmodule

// File: tb/tb_t1us_gen.sv
// Directed, table-driven bench for t1us_gen: period shapes, alignment,
// boundary alignment, enable, div change, second marker and reset.
module tb_t1us_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] div = 16'd0;
    logic [15:0] hi_len = 16'd0;
    logic        sync_in = 1'b0;

    logic        t1us, sec_pulse, locked, sync_err;
    logic [31:0] usec_cnt;
    logic        t1us_s, sec_pulse_s, locked_s, sync_err_s;
    logic [31:0] usec_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    t1us_gen dut (
        .clk(clk), .reset(reset), .en(en), .div(div), .hi_len(hi_len),
        .sync_in(sync_in), .t1us(t1us), .usec_cnt(usec_cnt),
        .sec_pulse(sec_pulse), .locked(locked), .sync_err(sync_err)
    );

    t1us_gen #(.US_PER_SEC(10)) dut_s (
        .clk(clk), .reset(reset), .en(en), .div(div), .hi_len(hi_len),
        .sync_in(sync_in), .t1us(t1us_s), .usec_cnt(usec_cnt_s),
        .sec_pulse(sec_pulse_s), .locked(locked_s), .sync_err(sync_err_s)
    );

    typedef struct {
        logic [15:0] div;
        logic [15:0] hi;
        int          exp_hi;
        int          exp_lo;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        en      = 1'b0;
        sync_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Counts cycles t1us stays at lvl, including the current one.
    task automatic count_while(input logic lvl, output int n);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (t1us !== lvl) break;
            n++;
        end
    endtask

    task automatic wait_rise(output int n);
        logic prev;
        prev = t1us;
        n = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            n++;
            if (t1us && !prev) break;
            prev = t1us;
        end
    endtask

    initial begin
        int h, l, n;
        int pulses, pulses_def, first_pulse, last_pulse;

        vecs[0] = '{16'd100, 16'd50, 50, 50};
        vecs[1] = '{16'd1,   16'd0,  1,  1};
        vecs[2] = '{16'd10,  16'd12, 9,  1};
        vecs[3] = '{16'd4,   16'd1,  1,  3};
        vecs[4] = '{16'd0,   16'd5,  1,  1};
        vecs[5] = '{16'd7,   16'd3,  3,  4};

        do_reset();
        chk("reset_t1us", {31'd0, t1us}, 32'd0);
        chk("reset_usec", usec_cnt, 32'd0);
        chk("reset_sec_pulse", {31'd0, sec_pulse}, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_sync_err", {31'd0, sync_err}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            div    = vecs[v].div;
            hi_len = vecs[v].hi;
            en     = 1'b1;
            tick();
            chk($sformatf("v%0d_first_rise", v), {31'd0, t1us}, 32'd1);
            chk($sformatf("v%0d_usec1", v), usec_cnt, 32'd1);
            count_while(1'b1, h);
            chk($sformatf("v%0d_high", v), h, vecs[v].exp_hi);
            count_while(1'b0, l);
            chk($sformatf("v%0d_low", v), l, vecs[v].exp_lo);
            chk($sformatf("v%0d_usec2", v), usec_cnt, 32'd2);
            $display("vec %0d div=%0d hi_len=%0d high=%0d low=%0d", v, vecs[v].div, vecs[v].hi, h, l);
        end

        // First alignment in mid-LOW, then a misaligned one while locked.
        do_reset();
        div = 16'd100; hi_len = 16'd50; en = 1'b1;
        tick();
        repeat (80) tick();
        chk("a_pre_low", {31'd0, t1us}, 32'd0);
        sync_in = 1'b1;
        repeat (4) tick();
        chk("a_latency_not_yet", {31'd0, t1us}, 32'd0);
        tick();
        chk("a_forced_rise", {31'd0, t1us}, 32'd1);
        chk("a_usec_load", usec_cnt, 32'd1);
        chk("a_sec_pulse", {31'd0, sec_pulse}, 32'd1);
        chk("a_locked", {31'd0, locked}, 32'd1);
        chk("a_no_err_first", {31'd0, sync_err}, 32'd0);
        sync_in = 1'b0;
        tick();
        chk("a_sec_pulse_one_clk", {31'd0, sec_pulse}, 32'd0);
        repeat (279) tick();
        chk("a_usec_before_realign", usec_cnt, 32'd3);
        sync_in = 1'b1;
        repeat (4) tick();
        chk("a2_latency_not_yet", {31'd0, t1us}, 32'd0);
        tick();
        chk("a2_forced_rise", {31'd0, t1us}, 32'd1);
        chk("a2_usec_load", usec_cnt, 32'd1);
        chk("a2_sec_pulse", {31'd0, sec_pulse}, 32'd1);
        chk("a2_sync_err", {31'd0, sync_err}, 32'd1);
        $display("alignment sequence usec=%0d sync_err=%0d", usec_cnt, sync_err);
        sync_in = 1'b0;
        div = 16'd4; hi_len = 16'd2;
        repeat (112) tick();
        chk("r_high_before_reset", {31'd0, t1us}, 32'd1);
        chk("r_usec5", usec_cnt, 32'd5);
        chk("r_err_sticky", {31'd0, sync_err}, 32'd1);
        reset = 1'b1;
        tick();
        chk("r_t1us", {31'd0, t1us}, 32'd0);
        chk("r_usec", usec_cnt, 32'd0);
        chk("r_locked", {31'd0, locked}, 32'd0);
        chk("r_sync_err", {31'd0, sync_err}, 32'd0);
        reset = 1'b0;

        // Alignment landing on the natural boundary.
        do_reset();
        div = 16'd10; hi_len = 16'd5; en = 1'b1;
        tick();
        sync_in = 1'b1;
        repeat (5) tick();
        chk("b_forced_rise", {31'd0, t1us}, 32'd1);
        chk("b_locked", {31'd0, locked}, 32'd1);
        sync_in = 1'b0;
        repeat (15) tick();
        sync_in = 1'b1;
        repeat (4) tick();
        chk("b_last_low", {31'd0, t1us}, 32'd0);
        tick();
        chk("b_boundary_rise", {31'd0, t1us}, 32'd1);
        chk("b_usec_load", usec_cnt, 32'd1);
        chk("b_no_err", {31'd0, sync_err}, 32'd0);
        chk("b_sec_pulse", {31'd0, sec_pulse}, 32'd1);
        repeat (5) tick();
        chk("b_low_after", {31'd0, t1us}, 32'd0);
        chk("b_usec_hold", usec_cnt, 32'd1);
        $display("boundary alignment usec=%0d sync_err=%0d", usec_cnt, sync_err);

        // en=0 idles the output, holds the count and masks alignment.
        en = 1'b0;
        tick();
        chk("c_idle_t1us", {31'd0, t1us}, 32'd0);
        chk("c_usec_hold", usec_cnt, 32'd1);
        sync_in = 1'b0;
        repeat (6) tick();
        sync_in = 1'b1;
        repeat (8) tick();
        chk("c_sync_ignored_t1us", {31'd0, t1us}, 32'd0);
        chk("c_sync_ignored_usec", usec_cnt, 32'd1);
        en = 1'b1;
        tick();
        chk("c_resume_rise", {31'd0, t1us}, 32'd1);
        chk("c_resume_usec", usec_cnt, 32'd2);
        sync_in = 1'b0;
        $display("enable sequence usec=%0d", usec_cnt);

        // div change mid-HIGH applies only from the next period.
        do_reset();
        div = 16'd100; hi_len = 16'd50; en = 1'b1;
        tick();
        repeat (10) tick();
        div = 16'd20; hi_len = 16'd10;
        wait_rise(n);
        chk("d_rest_of_period", n, 32'd90);
        wait_rise(n);
        chk("d_new_period", n, 32'd20);
        $display("div change next period=%0d", n);

        // Second marker with US_PER_SEC=10 and div=4.
        do_reset();
        div = 16'd4; hi_len = 16'd2; en = 1'b1;
        pulses = 0; pulses_def = 0; first_pulse = -1; last_pulse = -1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            tick();
            if (sec_pulse) pulses_def++;
            if (sec_pulse_s) begin
                pulses++;
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
                chk("e_pulse_on_rise", {31'd0, t1us_s}, 32'd1);
            end
        end
        chk("e_pulse_count", pulses, 32'd2);
        chk("e_first_pulse", first_pulse, 32'd37);
        chk("e_pulse_gap", last_pulse - first_pulse, 32'd40);
        chk("e_default_no_pulse", pulses_def, 32'd0);
        $display("second marker pulses=%0d first=%0d last=%0d", pulses, first_pulse, last_pulse);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
